// File: rtl/ifu_fetch.sv
// Instruction-fetch initiator: owns the PC, keeps one request outstanding to imem,
// buffers {pc, inst} for decode and discards wrong-path responses after a redirect.
module ifu_fetch #(
  parameter int              XLEN   = 64,
  parameter int              ILEN   = 32,
  parameter logic [XLEN-1:0] PC_RST = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_inst,
  input  logic            out_ready
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'd4};
  localparam logic [XLEN-1:0] ALIGN_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};

  logic [1:0]      state_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] req_pc_r;
  logic            drop_r;
  logic [XLEN-1:0] redirect_target_s;
  logic            req_fire_s;

  assign redirect_target_s = redirect_pc & ALIGN_MASK;
  // The request is gated by rst so nothing escapes while the block is held in reset.
  assign imem_req_valid    = !rst && (state_r == ST_REQ);
  assign imem_req_addr     = pc_r;
  assign req_fire_s        = imem_req_valid && imem_req_ready;

  // PC, fetch FSM, wrong-path drop flag and the decode output buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_REQ;
      pc_r      <= PC_RST;
      req_pc_r  <= {XLEN{1'b0}};
      drop_r    <= 1'b0;
      out_valid <= 1'b0;
      out_pc    <= {XLEN{1'b0}};
      out_inst  <= {ILEN{1'b0}};
    end else if (redirect_valid) begin
      // Redirect wins over every other event; only the in-flight bookkeeping differs per state.
      pc_r <= redirect_target_s;
      case (state_r)
        ST_REQ: begin
          if (req_fire_s) begin
            drop_r  <= 1'b1;
            state_r <= ST_WAIT;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            drop_r  <= 1'b0;
            state_r <= ST_REQ;
          end else begin
            drop_r  <= 1'b1;
            state_r <= ST_WAIT;
          end
        end
        ST_HOLD: begin
          out_valid <= 1'b0;
          state_r   <= ST_REQ;
        end
        default: begin
          drop_r    <= 1'b0;
          out_valid <= 1'b0;
          state_r   <= ST_REQ;
        end
      endcase
    end else begin
      case (state_r)
        ST_REQ: begin
          if (req_fire_s) begin
            req_pc_r <= pc_r;
            state_r  <= ST_WAIT;
          end else begin
            state_r  <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid && drop_r) begin
            drop_r  <= 1'b0;
            state_r <= ST_REQ;
          end else if (imem_rsp_valid) begin
            out_inst  <= imem_rsp_data;
            out_pc    <= req_pc_r;
            out_valid <= 1'b1;
            pc_r      <= req_pc_r + PC_STEP;
            state_r   <= ST_HOLD;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= ST_REQ;
          end else begin
            state_r   <= ST_HOLD;
          end
        end
        default: begin
          drop_r    <= 1'b0;
          out_valid <= 1'b0;
          state_r   <= ST_REQ;
        end
      endcase
    end
  end

endmodule
